// File: rtl/simon_seq_core.sv
// Simon memory game core: LFSR colour sequence, timed playback, player echo check.
// Optional feature macro SIMON_TIMEOUT_EN: ACCEPT gives up (LOSE) after TIMEOUT_CYCLES idle cycles.
module simon_seq_core #(
    parameter int NUM_COLORS     = 4,
    parameter int MAX_LEN        = 10,
    parameter int BLINK_CYCLES   = 25000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0
);
    localparam int CW   = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int TMAX = (BLINK_CYCLES > GAP_CYCLES) ? BLINK_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [2:0] S_START     = 3'd0;
    localparam logic [2:0] S_GEN       = 3'd1;
    localparam logic [2:0] S_BLINK_ON  = 3'd2;
    localparam logic [2:0] S_BLINK_OFF = 3'd3;
    localparam logic [2:0] S_ACCEPT    = 3'd4;
    localparam logic [2:0] S_CHECK     = 3'd5;
    localparam logic [2:0] S_WIN       = 3'd6;
    localparam logic [2:0] S_LOSE      = 3'd7;

    logic                  rst_n;
    logic [2:0]            state;
    logic [15:0]           lfsr;
    logic                  lfsr_fb;
    logic [LW-1:0]         len;
    logic [LW-1:0]         idx;
    logic [TW-1:0]         tmr;
    logic [NUM_COLORS-1:0] sw_q;
    logic [NUM_COLORS-1:0] sw_d;
    logic [NUM_COLORS-1:0] guess;
    logic [NUM_COLORS-1:0] want;
    logic                  press;
    logic                  last;
    logic                  timeout;
    logic [3:0]            digit;
    logic                  unused_inputs;
    // Sized to the full index range so every len/idx value addresses a real entry.
    logic [CW-1:0]         mem [0:(2**LW)-1];

    assign rst_n         = KEY[0];
    assign unused_inputs = ^{KEY[3:1], SW};
    assign lfsr_fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign want          = NUM_COLORS'(1) << mem[idx];
    assign last          = (idx + LW'(1)) == len;
    // A press is the registered bus leaving all-zero; a held bus never re-triggers.
    assign press         = (sw_q != '0) && (sw_d == '0);

`ifdef SIMON_TIMEOUT_EN
    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TOW-1:0] to_cnt;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)                              to_cnt <= '0;
        else if (state == S_ACCEPT && !press)    to_cnt <= to_cnt + TOW'(1);
        else                                     to_cnt <= '0;
    end

    assign timeout = (state == S_ACCEPT) && (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_START;
            lfsr  <= 16'hACE1;
            len   <= '0;
            idx   <= '0;
            tmr   <= '0;
            sw_q  <= '0;
            sw_d  <= '0;
            guess <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            sw_q <= SW[NUM_COLORS-1:0];
            sw_d <= sw_q;
            case (state)
                S_START: begin
                    len   <= '0;
                    state <= S_GEN;
                end
                S_GEN: begin
                    len   <= len + LW'(1);
                    idx   <= '0;
                    tmr   <= '0;
                    state <= S_BLINK_ON;
                end
                S_BLINK_ON: begin
                    if (tmr == TW'(BLINK_CYCLES - 1)) begin
                        tmr   <= '0;
                        state <= S_BLINK_OFF;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                S_BLINK_OFF: begin
                    if (tmr == TW'(GAP_CYCLES - 1)) begin
                        tmr <= '0;
                        if (last) begin
                            idx   <= '0;
                            state <= S_ACCEPT;
                        end else begin
                            idx   <= idx + LW'(1);
                            state <= S_BLINK_ON;
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                S_ACCEPT: begin
                    if (press) begin
                        guess <= sw_q;
                        state <= S_CHECK;
                    end else if (timeout) begin
                        state <= S_LOSE;
                    end
                end
                S_CHECK: begin
                    // Equality with a one-hot decode rejects multi-bit guesses too.
                    if (guess != want)            state <= S_LOSE;
                    else if (!last) begin
                        idx   <= idx + LW'(1);
                        state <= S_ACCEPT;
                    end
                    else if (len == LW'(MAX_LEN)) state <= S_WIN;
                    else                          state <= S_GEN;
                end
                S_LOSE: begin
                    if (tmr == TW'(BLINK_CYCLES - 1)) begin
                        tmr   <= '0;
                        state <= S_START;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                S_WIN:   state <= S_WIN;
                default: state <= S_START;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (state == S_GEN) mem[len] <= CW'(lfsr[4:0] % 5'(NUM_COLORS));
    end

    always_comb begin
        LEDR = '0;
        case (state)
            S_BLINK_ON: LEDR[NUM_COLORS-1:0] = want;
            S_ACCEPT:   LEDR[7] = 1'b1;
            S_LOSE:     LEDR[8] = 1'b1;
            S_WIN:      LEDR[9] = 1'b1;
            default:    ;
        endcase
    end

    assign digit = 4'(6'(len) % 6'd10);

    always_comb begin
        case (digit)
            4'd0:    HEX0 = 7'b1000000;
            4'd1:    HEX0 = 7'b1111001;
            4'd2:    HEX0 = 7'b0100100;
            4'd3:    HEX0 = 7'b0110000;
            4'd4:    HEX0 = 7'b0011001;
            4'd5:    HEX0 = 7'b0010010;
            4'd6:    HEX0 = 7'b0000010;
            4'd7:    HEX0 = 7'b1111000;
            4'd8:    HEX0 = 7'b0000000;
            4'd9:    HEX0 = 7'b0010000;
            default: HEX0 = 7'b1111111;
        endcase
    end
endmodule

// File: tb/tb_simon_seq_core.sv
// Directed bench for simon_seq_core: table-driven winning game plus lose/hold/reset/timeout sequences.
module tb_simon_seq_core;
    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;

    typedef struct {
        int         len;
        logic [6:0] hex;
        logic [2:0] flags_end;
    } round_t;

    logic       clk;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0;

    int n_tests = 0;
    int n_fail  = 0;
    int seq [0:2];

    simon_seq_core #(
        .NUM_COLORS(4), .MAX_LEN(3), .BLINK_CYCLES(2), .GAP_CYCLES(1), .TIMEOUT_CYCLES(20)
    ) dut (
        .CLOCK_50(clk), .KEY(KEY), .SW(SW), .LEDR(LEDR), .HEX0(HEX0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int c);
        logic [3:0] v;
        v = 4'b0001;
        return v << c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        KEY[0] = 1'b0;
        SW     = '0;
        @(negedge clk);
        chk("reset_ledr", LEDR, 10'd0);
        chk("reset_hex", HEX0, H0);
        KEY[0] = 1'b1;
        @(negedge clk);
        chk("release_dark", LEDR, 10'd0);
        @(negedge clk);
        chk("first_lamp_latency", 32'(LEDR[3:0] != 4'd0), 1);
    endtask

    task automatic playback(input int len);
        int t, cnt, c;
        logic [3:0] lamp;
        for (int i = 0; i < len; i++) begin
            t = 0;
            while (LEDR[3:0] == 4'd0 && t < 40) begin @(negedge clk); t++; end
            chk("lamp_wait", 32'(t < 40), 1);
            lamp = LEDR[3:0];
            chk("lamp_onehot", $countones(lamp), 1);
            chk("blink_flags", LEDR[9:4], 6'd0);
            c = 0;
            for (int b = 0; b < 4; b++) if (lamp[b]) c = b;
            seq[i] = c;
            cnt = 0;
            while (LEDR[3:0] == lamp && cnt < 10) begin @(negedge clk); cnt++; end
            chk("lamp_cycles", cnt, 2);
        end
        t = 0;
        while (LEDR[7] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        chk("accept_wait", 32'(t < 40), 1);
    endtask

    // Returns at the first negedge after CHECK has resolved.
    task automatic press(input logic [3:0] v);
        @(negedge clk);
        SW[3:0] = v;
        repeat (2) @(negedge clk);
        SW = '0;
        @(negedge clk);
    endtask

    initial begin
        round_t rounds [3];
        int     bad, n, t;

        KEY = 4'hF;
        SW  = '0;
        rounds[0] = '{1, H1, 3'b000};
        rounds[1] = '{2, H2, 3'b000};
        rounds[2] = '{3, H3, 3'b100};

        // Winning game
        do_reset();
        for (int r = 0; r < 3; r++) begin
            playback(rounds[r].len);
            chk("round_hex", HEX0, rounds[r].hex);
            chk("round_accept", LEDR[9:7], 3'b001);
            for (int i = 0; i < rounds[r].len; i++) begin
                press(onehot(seq[i]));
                chk("press_flags", LEDR[9:7],
                    (i == rounds[r].len - 1) ? rounds[r].flags_end : 3'b001);
            end
        end
        repeat (10) @(negedge clk);
        chk("win_held", LEDR, 10'h200);
        chk("win_hex", HEX0, H3);

        // Wrong colour on second press of round 2
        do_reset();
        playback(1);
        press(onehot(seq[0]));
        playback(2);
        press(onehot(seq[0]));
        chk("r2_first_ok", LEDR[9:7], 3'b001);
        press(onehot((seq[1] + 1) % 4));
        chk("lose_c1", LEDR[9:7], 3'b010);
        @(negedge clk);
        chk("lose_c2", LEDR[8], 1'b1);
        @(negedge clk);
        chk("lose_to_start", LEDR, 10'd0);
        playback(1);
        chk("after_lose_hex", HEX0, H1);

        // Multi-bit press, then bus held across ACCEPT re-entry
        @(negedge clk);
        SW[3:0] = 4'b0101;
        repeat (3) @(negedge clk);
        chk("multi_lose", LEDR[9:7], 3'b010);
        playback(1);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (LEDR[7] !== 1'b1) bad++;
        end
        chk("held_no_check", bad, 0);
        SW = '0;
        repeat (2) @(negedge clk);
        press(onehot(seq[0]));
        chk("held_release_ok", LEDR[9:7], 3'b000);
        playback(2);
        chk("held_next_hex", HEX0, H2);

        // Async reset during round-2 playback
        do_reset();
        playback(1);
        press(onehot(seq[0]));
        t = 0;
        while (LEDR[3:0] == 4'd0 && t < 40) begin @(negedge clk); t++; end
        chk("r2_lamp_wait", 32'(t < 40), 1);
        #2 KEY[0] = 1'b0;
        #1;
        chk("async_ledr", LEDR, 10'd0);
        chk("async_hex", HEX0, H0);
        do_reset();
        playback(1);
        chk("restart_hex", HEX0, H1);

        // Idle in ACCEPT
        n = 0;
        while (LEDR[7] === 1'b1 && n < 60) begin n++; @(negedge clk); end
`ifdef SIMON_TIMEOUT_EN
        chk("timeout_cycles", n, 20);
        chk("timeout_lose", LEDR[9:7], 3'b010);
`else
        chk("no_timeout_cycles", n, 60);
        chk("no_timeout_accept", LEDR[9:7], 3'b001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
